// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
//   - mdu_op_e    : operation codes driven by the EX stage
//   - mdu_state_e : sequencer states
//   - DIV_ZERO_LO : quotient returned for a divide by zero
//   - op_is_signed: true for MULT and DIV
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-divide iteration.
// Ports:
//   rem       in  W+1  partial remainder
//   quot      in  W    quotient register (dividend bits still shifting out at the top)
//   divisor   in  W+1  divisor magnitude, zero-extended
//   rem_next  out W+1  remainder after shift and conditional subtract
//   quot_next out W    quotient with the new bit shifted in at the bottom
// The shifted pair is W+2 bits wide so the trial subtraction's sign bit is
// available without losing any remainder bit.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quot,
  input  logic [W:0]   divisor,
  output logic [W:0]   rem_next,
  output logic [W-1:0] quot_next
);

  logic [W+1:0] shifted_s;
  logic [W+1:0] diff_s;

  // Shift {rem,quot} left by one, trial-subtract, keep the difference when non-negative
  always_comb begin
    shifted_s = {rem, quot[W-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    if (!diff_s[W+1]) begin
      rem_next  = diff_s[W:0];
      quot_next = {quot[W-2:0], 1'b1};
    end else begin
      rem_next  = shifted_s[W:0];
      quot_next = {quot[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EX-stage multiply/divide sequencer (MULT/MULTU/DIV/DIVU).
// Multiply is a registered 64-bit product held for MUL_LAT cycles; divide is
// a DIV_BITS-iteration restoring divide on operand magnitudes with sign
// fix-up applied as the results are loaded.
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset
//   start     in   1   EX holds an MDU op (held until consumed)
//   op        in   2   mdu_op_e encoding
//   src_a     in   32  multiplicand / dividend
//   src_b     in   32  multiplier / divisor
//   flush     in   1   abort any operation in flight
//   ready     out  1   low stalls EX (combinational)
//   done      out  1   one-cycle pulse, results valid
//   result_hi out  32  product high word / remainder
//   result_lo out  32  product low word / quotient
// Optional feature macro: MDU_EARLY_OUT_EN -- a divide whose divisor magnitude
// exceeds the dividend magnitude completes straight from IDLE (lo=0, hi=src_a).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DIV_BITS-1:0] src_a,
  input  logic [DIV_BITS-1:0] src_b,
  input  logic                flush,
  output logic                ready,
  output logic                done,
  output logic [DIV_BITS-1:0] result_hi,
  output logic [DIV_BITS-1:0] result_lo
);

  localparam int W       = DIV_BITS;
  localparam int CNT_MAX = (MUL_LAT > DIV_BITS) ? MUL_LAT : DIV_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

  mdu_state_e       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     a_r;
  logic             neg_q_r, neg_r_r, dbz_r;
  logic [2*W-1:0]   prod_r;
  logic [W:0]       rem_r, dvs_r;
  logic [W-1:0]     quot_r;
  logic             done_r;
  logic [W-1:0]     hi_r, lo_r;

  logic             is_signed_s, is_mul_s, launch_s, cnt_zero_s;
  logic [W-1:0]     mag_a_s, mag_b_s;
  logic [2*W-1:0]   ext_a_s, ext_b_s;
  logic [W:0]       rem_step_s;
  logic [W-1:0]     quot_step_s, quot_fix_s, rem_fix_s, div_hi_s, div_lo_s;

  assign is_signed_s = op_is_signed(op);
  assign is_mul_s    = (op == MDU_MULT) || (op == MDU_MULTU);
  assign launch_s    = (state_r == IDLE) && start && !flush;
  assign cnt_zero_s  = (cnt_r == CNT_ZERO);

  // Operand magnitudes (MIN_INT maps to 2^(W-1), which still fits unsigned) and product extension
  always_comb begin
    if (is_signed_s && src_a[W-1]) begin
      mag_a_s = ~src_a + W'(1);
    end else begin
      mag_a_s = src_a;
    end
    if (is_signed_s && src_b[W-1]) begin
      mag_b_s = ~src_b + W'(1);
    end else begin
      mag_b_s = src_b;
    end
    ext_a_s = {{W{is_signed_s & src_a[W-1]}}, src_a};
    ext_b_s = {{W{is_signed_s & src_b[W-1]}}, src_b};
  end

`ifdef MDU_EARLY_OUT_EN
  logic early_s;
  assign early_s = !is_mul_s && (mag_b_s > mag_a_s);
`endif

  mdu_div_step #(.W(W)) u_step (
    .rem       (rem_r),
    .quot      (quot_r),
    .divisor   (dvs_r),
    .rem_next  (rem_step_s),
    .quot_next (quot_step_s)
  );

  // Sign fix-up and divide-by-zero override on the final iteration's output
  always_comb begin
    if (neg_q_r) begin
      quot_fix_s = ~quot_step_s + W'(1);
    end else begin
      quot_fix_s = quot_step_s;
    end
    if (neg_r_r) begin
      rem_fix_s = ~rem_step_s[W-1:0] + W'(1);
    end else begin
      rem_fix_s = rem_step_s[W-1:0];
    end
    if (dbz_r) begin
      div_hi_s = a_r;
      div_lo_s = DIV_ZERO_LO;
    end else begin
      div_hi_s = rem_fix_s;
      div_lo_s = quot_fix_s;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (is_mul_s) begin
              state_next_s = MUL;
            end else begin
`ifdef MDU_EARLY_OUT_EN
              state_next_s = early_s ? DONE : DIV;
`else
              state_next_s = DIV;
`endif
            end
          end else begin
            state_next_s = IDLE;
          end
        end
        MUL:     state_next_s = cnt_zero_s ? DONE : MUL;
        DIV:     state_next_s = cnt_zero_s ? DONE : DIV;
        DONE:    state_next_s = IDLE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= CNT_ZERO;
      a_r     <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dbz_r   <= 1'b0;
      prod_r  <= '0;
      rem_r   <= '0;
      quot_r  <= '0;
      dvs_r   <= '0;
      done_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      done_r <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            a_r     <= src_a;
            neg_q_r <= is_signed_s && (src_a[W-1] ^ src_b[W-1]);
            neg_r_r <= is_signed_s && src_a[W-1];
            dbz_r   <= (src_b == '0);
            prod_r  <= ext_a_s * ext_b_s;
            rem_r   <= '0;
            quot_r  <= mag_a_s;
            dvs_r   <= {1'b0, mag_b_s};
            cnt_r   <= is_mul_s ? MUL_CNT_INIT : DIV_CNT_INIT;
`ifdef MDU_EARLY_OUT_EN
            if (early_s) begin
              hi_r <= src_a;
              lo_r <= '0;
            end
`endif
          end
        end
        MUL: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_zero_s && !flush) begin
            hi_r <= prod_r[2*W-1:W];
            lo_r <= prod_r[W-1:0];
          end
        end
        DIV: begin
          cnt_r  <= cnt_r - CNT_W'(1);
          rem_r  <= rem_step_s;
          quot_r <= quot_step_s;
          if (cnt_zero_s && !flush) begin
            hi_r <= div_hi_s;
            lo_r <= div_lo_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign ready     = ((state_r == IDLE) && !start) || (state_r == DONE);
  assign done      = done_r;
  assign result_hi = hi_r;
  assign result_lo = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized self-checking bench for mdu_ctrl. A latency-and-
// arithmetic reference model predicts ready/done/result_hi/result_lo every
// cycle; directed cases pin the model with hand-computed values.
module tb_mdu_ctrl;

  localparam int MUL_LAT  = 2;
  localparam int DIV_BITS = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk, rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        ready, done;
  logic [31:0] result_hi, result_lo;

  int checks   = 0;
  int failures = 0;

  // model state
  bit          m_busy, m_done;
  int          m_left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_BITS(DIV_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .ready(ready), .done(done), .result_hi(result_hi), .result_lo(result_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic: results and latency (cycle of done, counting the launch cycle as 0)
  task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint sa, sb, q, r;
    logic [63:0] prod;
    logic [31:0] ma, mb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == OP_MULT || o == OP_MULTU) begin
      if (o == OP_MULT) prod = 64'(sa * sb);
      else              prod = {32'd0, a} * {32'd0, b};
      hi = prod[63:32];
      lo = prod[31:0];
      lat = MUL_LAT + 1;
    end else begin
      lat = DIV_BITS + 1;
      if (b == 32'd0) begin
        hi = a;
        lo = 32'hFFFF_FFFF;
      end else if (o == OP_DIV) begin
        q = sa / sb;
        r = sa % sb;
        hi = r[31:0];
        lo = q[31:0];
      end else begin
        hi = a % b;
        lo = a / b;
      end
      ma = (o == OP_DIV && a[31]) ? 32'(-sa) : a;
      mb = (o == OP_DIV && b[31]) ? 32'(-sb) : b;
`ifdef MDU_EARLY_OUT_EN
      if (mb > ma) lat = 1;
`else
      if (mb > ma) lat = DIV_BITS + 1;
`endif
    end
  endtask

  // Advance the model across one rising edge using the inputs the DUT samples there
  task automatic model_update();
    int lat;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    end else if (flush) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
      end
    end else if (start) begin
      ref_op(op, src_a, src_b, p_hi, p_lo, lat);
      if (lat == 1) begin
        m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
      end else begin
        m_busy = 1'b1; m_left = lat - 1;
      end
    end
  endtask

  task automatic compare_model();
    chk("ready", 64'(ready), 64'(m_done || (!m_busy && !start)));
    chk("done", 64'(done), 64'(m_done));
    chk("result_hi", 64'(result_hi), 64'(m_hi));
    chk("result_lo", 64'(result_lo), 64'(m_lo));
  endtask

  task automatic to_neg();
    @(negedge clk);
    compare_model();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Launch an op with start held until consumed; returns done cycle and captured results
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo);
    bit got;
    start = 1'b1; op = o; src_a = a; src_b = b;
    lat = -1; hi = 32'hDEAD_BEEF; lo = 32'hDEAD_BEEF;
    for (int c = 0; c < 100; c++) begin
      to_neg();
      got = done;
      if (got) begin
        hi = result_hi; lo = result_lo;
      end
      to_pos();
      if (got) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, dcount;
    logic [31:0] hi, lo;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) to_pos();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    to_pos();

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, lat, hi, lo);
    chk("multu_lat", 64'(lat), 64'd3);
    chk("multu_hi", 64'(hi), 64'h1);
    chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, hi, lo);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);

    run_op(OP_DIVU, 32'd100, 32'd7, lat, hi, lo);
    chk("divu_lat", 64'(lat), 64'd33);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    to_neg();
    chk("divu_idle_ready", 64'(ready), 64'd1);
    chk("divu_idle_done", 64'(done), 64'd0);
    to_pos();

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, hi, lo);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'd0);

    run_op(OP_DIV, 32'd9, 32'd0, lat, hi, lo);
    chk("dbz_lat", 64'(lat), 64'd33);
    chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("dbz_hi", 64'(hi), 64'd9);

    run_op(OP_DIVU, 32'd3, 32'd10, lat, hi, lo);
`ifdef MDU_EARLY_OUT_EN
    chk("early_lat", 64'(lat), 64'd1);
`else
    chk("early_lat", 64'(lat), 64'd33);
`endif
    chk("early_lo", 64'(lo), 64'd0);
    chk("early_hi", 64'(hi), 64'd3);

    // flush mid-divide with prior results hi=2 / lo=14
    run_op(OP_DIVU, 32'd100, 32'd7, lat, hi, lo);
    start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    for (int c = 0; c < 10; c++) begin
      to_neg();
      to_pos();
    end
    flush = 1'b1; start = 1'b0;
    to_neg();
    to_pos();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hi", 64'(result_hi), 64'd2);
    chk("flush_lo", 64'(result_lo), 64'd14);
    to_pos();
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      to_neg();
      if (done) dcount++;
      to_pos();
    end
    chk("flush_no_done", 64'(dcount), 64'd0);

    // reset at cycle 5 of a divide
    start = 1'b1; op = OP_DIVU; src_a = 32'd77; src_b = 32'd5;
    for (int c = 0; c < 5; c++) begin
      to_neg();
      to_pos();
    end
    rst = 1'b1; start = 1'b0;
    to_neg();
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    chk("rstdiv_ready", 64'(ready), 64'd1);
    chk("rstdiv_hi", 64'(result_hi), 64'd0);
    chk("rstdiv_lo", 64'(result_lo), 64'd0);
    to_pos();

    // reset during the multiply state
    run_op(OP_MULT, 32'd7, 32'd6, lat, hi, lo);
    chk("mul42_lo", 64'(lo), 64'd42);
    start = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    to_neg();
    to_pos();
    rst = 1'b1; start = 1'b0;
    to_neg();
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmul_done", 64'(done), 64'd0);
    chk("rstmul_lo", 64'(result_lo), 64'd0);
    to_pos();

    // randomized traffic, checked every cycle by compare_model
    for (int n = 0; n < 300; n++) begin
      int gap, mode, k;
      bit got;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        to_neg();
        to_pos();
      end
      mode = $urandom_range(0, 9);
      op = 2'($urandom_range(0, 3));
      src_a = rnd_operand();
      src_b = rnd_operand();
      if (mode == 0) begin
        start = 1'b1; flush = 1'b1;
        to_neg();
        to_pos();
        start = 1'b0; flush = 1'b0;
      end else if (mode == 1) begin
        start = 1'b1;
        k = $urandom_range(0, 35);
        got = 1'b0;
        for (int c = 0; c < k; c++) begin
          to_neg();
          got = done;
          to_pos();
          if (got) break;
        end
        start = 1'b0;
        if (!got) begin
          flush = 1'b1;
          to_neg();
          to_pos();
          flush = 1'b0;
        end
      end else begin
        run_op(op, src_a, src_b, lat, hi, lo);
      end
    end

    to_neg();
    to_pos();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
